// File: rtl/lab5_cpu_pkg.sv
// Shared constants, fetch state encoding and IF/ID payload type for the lab5 16-bit CPU.
package lab5_cpu_pkg;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned INSTR_W = 16;
    localparam int unsigned PC_STEP = 2;

    localparam logic [ADDR_W-1:0]  RESET_PC  = 8'h00;
    localparam logic [INSTR_W-1:0] HALT_WORD = 16'h0000;

    typedef enum logic {
        FETCH_RUN  = 1'b0,
        FETCH_HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
        logic [ADDR_W-1:0]  pc_next;
    } ifid_t;

endpackage

// File: rtl/lab5_next_pc.sv
// Combinational next-PC select: reset, redirect, hold or sequential step, always halfword aligned.
module lab5_next_pc
    import lab5_cpu_pkg::*;
(
    input  logic              reset,
    input  logic              redirect,
    input  logic              hold,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] next_pc_c
);

    always_comb begin
        next_pc_c = pc;
        if (reset) begin
            next_pc_c = RESET_PC;
        end else if (redirect) begin
            next_pc_c = redirect_pc;
        end else if (!hold) begin
            next_pc_c = pc + ADDR_W'(PC_STEP);
        end
        // Instructions are halfword aligned; odd targets are truncated.
        next_pc_c[0] = 1'b0;
    end

endmodule

// File: rtl/lab5_fetch_stage.sv
// Instruction-fetch stage: owns the PC, captures the instruction word into IF/ID,
// and handles stall, redirect-with-flush and halt on an empty memory word.
module lab5_fetch_stage
    import lab5_cpu_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET,
    output logic [ADDR_W-1:0]  IMEM_ADDR,
    input  logic [INSTR_W-1:0] IMEM_Q,
    input  logic               STALL,
    input  logic               REDIRECT,
    input  logic [ADDR_W-1:0]  REDIRECT_PC,
    output logic [INSTR_W-1:0] IFID_INSTR,
    output logic [ADDR_W-1:0]  IFID_PC,
    output logic [ADDR_W-1:0]  IFID_PC_NEXT,
    output logic               IFID_VALID,
    output logic               HALTED
);

    fetch_state_e      state;
    fetch_state_e      next_state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] next_pc;
    logic              hold;
    ifid_t             ifid;
    ifid_t             ifid_d;
    logic              valid;
    logic              valid_d;

    lab5_next_pc u_next_pc (
        .reset       (RESET),
        .redirect    (REDIRECT),
        .hold        (hold),
        .pc          (pc),
        .redirect_pc (REDIRECT_PC),
        .next_pc_c   (next_pc)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= FETCH_RUN;
        end else begin
            state <= next_state;
        end
    end

    // Priority below reset: redirect, halted, stall, halt-word detect, normal fetch.
    always_comb begin
        next_state = state;
        ifid_d     = ifid;
        valid_d    = valid;
        hold       = 1'b0;
        if (REDIRECT) begin
            next_state = FETCH_RUN;
            valid_d    = 1'b0;
        end else if (state == FETCH_HALT) begin
            hold    = 1'b1;
            valid_d = 1'b0;
        end else if (STALL) begin
            hold = 1'b1;
        end else if (IMEM_Q == HALT_WORD) begin
            next_state = FETCH_HALT;
            hold       = 1'b1;
            valid_d    = 1'b0;
        end else begin
            ifid_d.instr   = IMEM_Q;
            ifid_d.pc      = pc;
            ifid_d.pc_next = pc + ADDR_W'(PC_STEP);
            valid_d        = 1'b1;
        end
    end

    // The reset value comes through the next-PC select.
    always_ff @(posedge CLK) begin
        pc <= next_pc;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ifid  <= '0;
            valid <= 1'b0;
        end else begin
            ifid  <= ifid_d;
            valid <= valid_d;
        end
    end

    assign IMEM_ADDR    = pc;
    assign IFID_INSTR   = ifid.instr;
    assign IFID_PC      = ifid.pc;
    assign IFID_PC_NEXT = ifid.pc_next;
    assign IFID_VALID   = valid;
    assign HALTED       = (state == FETCH_HALT);

endmodule
